// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad register block: button bit positions,
// CPU register addresses, open-bus default and stale-timer width.
package nes_joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic ADDR_4016 = 1'b0;
    localparam logic ADDR_4017 = 1'b1;

    localparam logic [2:0] OPEN_BUS_HI_DEF = 3'b010;

    localparam int STALE_W = 20;

endpackage

// File: rtl/nes_joypad_channel.sv
// Per-pad snapshot, presence timer, optional turbo gating and serial shift register.
// Snapshot/presence update one edge after valid; serial bit is combinational from the shift register.
// No backpressure: the reader's valid is sampled every cycle; turbo gating needs NES_JOYPAD_TURBO_EN.
module nes_joypad_channel
    import nes_joypad_pkg::*;
#(
    parameter int STALE_CYCLES = 900000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] state_i,
    input  logic       valid_i,
    input  logic [1:0] turbo_i,
    input  logic       turbo_phase_i,
    input  logic       strobe_i,
    input  logic       shift_i,
    output logic       serial_o,
    output logic       present_o
);

    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);

    logic [7:0]         snap_q;
    logic [7:0]         shreg_q, shreg_d;
    logic [STALE_W-1:0] stale_q;
    logic               present_q;
    logic [7:0]         eff_snap;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            snap_q    <= 8'h00;
            stale_q   <= '0;
            present_q <= 1'b0;
        end else if (valid_i) begin
            snap_q    <= state_i;
            stale_q   <= '0;
            present_q <= 1'b1;
        end else if (stale_q == STALE_LAST) begin
            // Saturated: pad is gone, so it must read as "no buttons".
            snap_q    <= 8'h00;
            present_q <= 1'b0;
        end else begin
            stale_q   <= stale_q + 1'b1;
        end
    end

`ifdef NES_JOYPAD_TURBO_EN
    always_comb begin
        eff_snap        = snap_q;
        eff_snap[BTN_A] = snap_q[BTN_A] & (~turbo_i[0] | turbo_phase_i);
        eff_snap[BTN_B] = snap_q[BTN_B] & (~turbo_i[1] | turbo_phase_i);
    end
`else
    wire unused_turbo = ^{turbo_i, turbo_phase_i};
    assign eff_snap = snap_q;
`endif

    always_comb begin
        shreg_d = shreg_q;
        if (strobe_i) begin
            shreg_d = eff_snap;
        end else if (shift_i) begin
            shreg_d = {1'b1, shreg_q[7:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shreg_q <= 8'h00;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign serial_o  = shreg_q[0];
    assign present_o = present_q;

endmodule

// File: rtl/nes_joypad_regs.sv
// CPU-facing $4016/$4017 joypad registers: strobe latch, per-pad serial readout, presence flags.
// Read data is combinational in the cycle of i_cpu_re; the shift takes effect at the end of that cycle.
// No backpressure: one shift per read strobe cycle. Optional turbo via NES_JOYPAD_TURBO_EN.
module nes_joypad_regs
    import nes_joypad_pkg::*;
#(
    parameter logic [2:0] OPEN_BUS_HI       = OPEN_BUS_HI_DEF,
    parameter int         STALE_CYCLES      = 900000,
    parameter int         TURBO_HALF_PERIOD = 1350000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_pad0_state,
    input  logic       i_pad0_valid,
    input  logic [7:0] i_pad1_state,
    input  logic       i_pad1_valid,
    input  logic [1:0] i_pad0_turbo,
    input  logic [1:0] i_pad1_turbo,
    input  logic       i_cpu_addr,
    input  logic       i_cpu_we,
    input  logic       i_cpu_re,
    input  logic [7:0] i_cpu_din,
    output logic [7:0] o_cpu_dout,
    output logic [1:0] o_pad_present
);

    logic strobe_q, strobe_d;
    logic turbo_phase;
    logic read_shift;
    logic serial0, serial1;

    wire unused_din = ^i_cpu_din[7:1];

    always_comb begin
        strobe_d = strobe_q;
        if (i_cpu_we && (i_cpu_addr == ADDR_4016)) begin
            strobe_d = i_cpu_din[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    // A read coinciding with a write returns data but never advances the shifter.
    assign read_shift = i_cpu_re & ~i_cpu_we;

`ifdef NES_JOYPAD_TURBO_EN
    localparam int TW = $clog2(TURBO_HALF_PERIOD + 1);
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_HALF_PERIOD - 1);

    logic [TW-1:0] turbo_cnt_q;
    logic          turbo_phase_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else if (turbo_cnt_q == TURBO_LAST) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= ~turbo_phase_q;
        end else begin
            turbo_cnt_q   <= turbo_cnt_q + 1'b1;
        end
    end

    assign turbo_phase = turbo_phase_q;
`else
    assign turbo_phase = 1'b0;
`endif

    nes_joypad_channel #(.STALE_CYCLES(STALE_CYCLES)) u_pad0 (
        .clk_i         (i_clk),
        .rst_n_i       (i_rst_n),
        .state_i       (i_pad0_state),
        .valid_i       (i_pad0_valid),
        .turbo_i       (i_pad0_turbo),
        .turbo_phase_i (turbo_phase),
        .strobe_i      (strobe_q),
        .shift_i       (read_shift & (i_cpu_addr == ADDR_4016)),
        .serial_o      (serial0),
        .present_o     (o_pad_present[0])
    );

    nes_joypad_channel #(.STALE_CYCLES(STALE_CYCLES)) u_pad1 (
        .clk_i         (i_clk),
        .rst_n_i       (i_rst_n),
        .state_i       (i_pad1_state),
        .valid_i       (i_pad1_valid),
        .turbo_i       (i_pad1_turbo),
        .turbo_phase_i (turbo_phase),
        .strobe_i      (strobe_q),
        .shift_i       (read_shift & (i_cpu_addr == ADDR_4017)),
        .serial_o      (serial1),
        .present_o     (o_pad_present[1])
    );

    assign o_cpu_dout = {OPEN_BUS_HI, 4'b0000,
                         (i_cpu_addr == ADDR_4017) ? serial1 : serial0};

endmodule

// File: tb/tb_nes_joypad_regs.sv
// Directed bench for nes_joypad_regs with shortened stale/turbo periods.
module tb_nes_joypad_regs;

    localparam int STALE = 20;
    localparam int HALF  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pad0_state, pad1_state;
    logic       pad0_valid, pad1_valid;
    logic [1:0] pad0_turbo, pad1_turbo;
    logic       cpu_addr, cpu_we, cpu_re;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic [1:0] pad_present;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nes_joypad_regs #(
        .OPEN_BUS_HI       (3'b010),
        .STALE_CYCLES      (STALE),
        .TURBO_HALF_PERIOD (HALF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pad0_state  (pad0_state),
        .i_pad0_valid  (pad0_valid),
        .i_pad1_state  (pad1_state),
        .i_pad1_valid  (pad1_valid),
        .i_pad0_turbo  (pad0_turbo),
        .i_pad1_turbo  (pad1_turbo),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_we      (cpu_we),
        .i_cpu_re      (cpu_re),
        .i_cpu_din     (cpu_din),
        .o_cpu_dout    (cpu_dout),
        .o_pad_present (pad_present)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        step();
        cpu_we   = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        cpu_addr = a;
        cpu_re   = 1'b1;
        @(negedge clk);
        d = cpu_dout;
        step();
        cpu_re   = 1'b0;
    endtask

    task automatic latch();
        cpu_write(1'b0, 8'h01);
        cpu_write(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (cpu_dout !== 8'h40) begin
            errors++;
            $display("FAIL reset_dout got=%h want=40", cpu_dout);
        end
        checks++;
        if (pad_present !== 2'b00) begin
            errors++;
            $display("FAIL reset_present got=%b want=00", pad_present);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        logic [7:0] d;
        logic [7:0] exp [9] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};
        pad0_state = 8'h01;
        pad0_valid = 1'b1;
        step();
        checks++;
        if (pad_present[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_present0 got=%b want=1", pad_present[0]);
        end
        latch();
        for (int i = 0; i < 9; i++) begin
            cpu_read(1'b0, d);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL basic_read%0d got=%h want=%h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_strobe_live();
        logic [7:0] d;
        cpu_write(1'b0, 8'h01);
        step();
        for (int i = 0; i < 3; i++) begin
            cpu_read(1'b0, d);
            checks++;
            if (d !== 8'h41) begin
                errors++;
                $display("FAIL strobe_live%0d got=%h want=41", i, d);
            end
        end
        cpu_write(1'b0, 8'h00);
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h41) begin
            errors++;
            $display("FAIL strobe_fall_first got=%h want=41", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("FAIL strobe_fall_second got=%h want=40", d);
        end
    endtask

    task automatic test_pad1_independent();
        logic [7:0] d;
        pad1_state = 8'h80;
        pad1_valid = 1'b1;
        step();
        latch();
        for (int i = 0; i < 8; i++) begin
            cpu_read(1'b1, d);
            checks++;
            if (d !== ((i == 7) ? 8'h41 : 8'h40)) begin
                errors++;
                $display("FAIL pad1_read%0d got=%h want=%h", i, d, (i == 7) ? 8'h41 : 8'h40);
            end
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h41) begin
            errors++;
            $display("FAIL pad0_after_pad1_a got=%h want=41", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("FAIL pad0_after_pad1_b got=%h want=40", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        latch();
        // Write and read in the same cycle: data returned, shifter held.
        cpu_addr = 1'b0;
        cpu_din  = 8'h00;
        cpu_we   = 1'b1;
        cpu_re   = 1'b1;
        @(negedge clk);
        d = cpu_dout;
        step();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        checks++;
        if (d !== 8'h41) begin
            errors++;
            $display("FAIL we_re_data got=%h want=41", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h41) begin
            errors++;
            $display("FAIL we_re_noshift got=%h want=41", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("FAIL we_re_next got=%h want=40", d);
        end
    endtask

    task automatic test_stale();
        logic [7:0] d;
        pad0_valid = 1'b0;
        repeat (STALE - 1) step();
        checks++;
        if (pad_present[0] !== 1'b1) begin
            errors++;
            $display("FAIL stale_early got=%b want=1", pad_present[0]);
        end
        step();
        checks++;
        if (pad_present !== 2'b10) begin
            errors++;
            $display("FAIL stale_timeout got=%b want=10", pad_present);
        end
        latch();
        for (int i = 0; i < 8; i++) begin
            cpu_read(1'b0, d);
            checks++;
            if (d !== 8'h40) begin
                errors++;
                $display("FAIL stale_read%0d got=%h want=40", i, d);
            end
        end
        pad0_valid = 1'b1;
        step();
        checks++;
        if (pad_present !== 2'b11) begin
            errors++;
            $display("FAIL stale_restore got=%b want=11", pad_present);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        pad0_state = 8'h01;
        latch();
        for (int i = 0; i < 3; i++) cpu_read(1'b0, d);
        rst_n = 1'b0;
        step();
        checks++;
        if (cpu_dout !== 8'h40) begin
            errors++;
            $display("FAIL midreset_dout got=%h want=40", cpu_dout);
        end
        checks++;
        if (pad_present !== 2'b00) begin
            errors++;
            $display("FAIL midreset_present got=%b want=00", pad_present);
        end
        rst_n = 1'b1;
        step();
        step();
        // Strobe must be clear: a live strobe would reload A=1 here.
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h40) begin
            errors++;
            $display("FAIL midreset_strobe got=%h want=40", d);
        end
    endtask

`ifdef NES_JOYPAD_TURBO_EN
    task automatic test_turbo();
        logic [7:0] r [3];
        pad0_state = 8'h01;
        pad0_turbo = 2'b01;
        for (int i = 0; i < 3; i++) begin
            latch();
            cpu_read(1'b0, r[i]);
            repeat (HALF - 3) step();
        end
        checks++;
        if (r[1] === r[0] || (r[0] !== 8'h40 && r[0] !== 8'h41)) begin
            errors++;
            $display("FAIL turbo_alt01 got=%h,%h want=differing 40/41", r[0], r[1]);
        end
        checks++;
        if (r[2] !== r[0]) begin
            errors++;
            $display("FAIL turbo_alt02 got=%h want=%h", r[2], r[0]);
        end
        pad0_turbo = 2'b00;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        pad0_state = 8'h00;
        pad1_state = 8'h00;
        pad0_valid = 1'b0;
        pad1_valid = 1'b0;
        pad0_turbo = 2'b00;
        pad1_turbo = 2'b00;
        cpu_addr   = 1'b0;
        cpu_we     = 1'b0;
        cpu_re     = 1'b0;
        cpu_din    = 8'h00;
        #1;
        test_reset();
        test_basic_read();
        test_strobe_live();
        test_pad1_independent();
        test_back_to_back();
        test_stale();
        test_reset_mid_read();
`ifdef NES_JOYPAD_TURBO_EN
        test_turbo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_joypad_regs.md
Name: nes_joypad_regs

Overview:
- CPU-side joypad register block for the NES core; sits directly downstream of the two NESGamepad serial readers.
- Takes each reader's parallel 8-bit button snapshot and its data-available flag.
- Presents the console's $4016/$4017 strobe/serial-read protocol to the 6502 bus: games latch on a strobe write, then read one button per access.
- Also tracks per-pad presence so a disconnected pad reads as "no buttons".

Parameters:
- OPEN_BUS_HI, 3'b010, value driven on o_cpu_dout[7:5] (open-bus emulation; gives the usual 0x40/0x41).
- STALE_CYCLES, 900000, i_clk cycles with no valid before a pad is declared absent (about 33 ms at 27 MHz).
- TURBO_HALF_PERIOD, 1350000, i_clk cycles per turbo phase (about 10 Hz toggle); used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_pad0_state  in  8  pad 0 buttons {Right,Left,Down,Up,Start,Select,B,A}, bit0 = A.
- i_pad0_valid  in  1  pad 0 snapshot valid (level; may stay high for many cycles).
- i_pad1_state  in  8  pad 1 buttons, same order.
- i_pad1_valid  in  1  pad 1 snapshot valid.
- i_pad0_turbo  in  2  turbo enables {B,A} for pad 0.
- i_pad1_turbo  in  2  turbo enables {B,A} for pad 1.
- i_cpu_addr  in  1  0 = $4016, 1 = $4017.
- i_cpu_we  in  1  write strobe, one cycle per CPU write.
- i_cpu_re  in  1  read strobe, one cycle per CPU read.
- i_cpu_din  in  8  write data; only bit0 is used.
- o_cpu_dout  out  8  read data = {OPEN_BUS_HI, 4'b0, serial bit}.
- o_pad_present  out  2  per-pad presence flags.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - strobe = 0, snapshots = 0, shift registers = 0, stale counters = 0, o_pad_present = 0.
  - o_cpu_dout = 8'h40 with default OPEN_BUS_HI.
  - Reset in the middle of a read sequence aborts it; no shift state survives.
- Snapshot capture:
  - On every cycle padN_valid is high: snapshot_N <= i_padN_state, stale counter_N <= 0, present_N <= 1.
- Stale timeout:
  - With valid low, counter_N increments.
  - When it reaches STALE_CYCLES-1: present_N <= 0, snapshot_N <= 0, counter saturates and does not wrap.
  - The next valid high restores present_N in the same edge.
- Strobe:
  - A write with i_cpu_addr = 0 sets strobe <= i_cpu_din[0].
  - Writes to $4017 are ignored (APU frame counter, outside this block).
- Shift register load:
  - While strobe = 1, both shift registers reload from the effective snapshot every cycle.
  - When strobe falls, the last loaded value is held.
- Read data:
  - o_cpu_dout is combinational. Bit0 = bit0 of the shift register selected by i_cpu_addr.
  - It is valid in the same cycle as i_cpu_re.
- Read shift:
  - A read with strobe = 0 shifts only the addressed register right at the end of that cycle, filling with 1.
  - After 8 reads, further reads return 1 (official-controller behaviour).
  - A read with strobe = 1 returns live A and does not shift.
- Simultaneous i_cpu_we and i_cpu_re: the write is applied, the read returns the pre-edge value, and no shift occurs.
- i_cpu_re held high for k cycles produces k shifts; the CPU core must pulse it once per access.
- Pad 0 and pad 1 are fully independent: a read of one never shifts the other.

Optional Feature:
- Macro: NES_JOYPAD_TURBO_EN.
- With the macro:
  - A free-running counter toggles turbo_phase every TURBO_HALF_PERIOD cycles; reset clears both counter and phase.
  - Effective A = snapshot.A & (~turbo.A | turbo_phase), and likewise for B.
  - Gating is applied at shift-register load time.
- Without the macro:
  - The turbo ports still exist but are ignored; effective snapshot = snapshot.
  - No turbo counter is synthesized.

Decomposition:
- Package nes_joypad_pkg holds:
  - button bit indices (BTN_A = 0 .. BTN_RIGHT = 7);
  - register address constants (ADDR_4016 = 0, ADDR_4017 = 1);
  - the default OPEN_BUS_HI;
  - the stale-counter width (20).
- Sub-module nes_joypad_channel, instantiated once per pad, contains the snapshot, stale timer, presence flag, turbo gating and shift register.
- The top level contains the strobe register, the turbo phase generator, address decode and output mux.

Test Plan:
- Reset; pad0_state = 8'h01 with valid; write 1 then 0 to $4016; 9 reads of $4016 -> 41,40,40,40,40,40,40,40,41.
- strobe = 1; pad0_state = 8'h01; 3 reads of $4016 -> 41,41,41 and no shift; write 0; next read -> 41, then 40.
- pad1_state = 8'h80 (Right); latch; 8 reads of $4017 -> seven 40s then 41; $4016 unaffected throughout.
- pad0 valid low for STALE_CYCLES -> o_pad_present[0] = 0; latch and 8 reads -> all 40; valid high again -> present = 1 on the next edge.
- After 3 reads of $4016, pull i_rst_n low for one cycle -> dout = 40, strobe = 0, all presence flags 0.
- With NES_JOYPAD_TURBO_EN: A held, turbo.A = 1, latch each phase -> A reads alternate 41/40 every TURBO_HALF_PERIOD cycles.
